// File: rtl/hp_ch_sched.sv
// Multi-channel scheduler sharing one highpass core: per-channel capture, round-robin grant, core handshake.
// Optional core-completion watchdog enabled by defining HP_SCHED_WDOG_EN.
module hp_ch_sched #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 24,
  parameter int WDOG_CYC = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CH-1:0]           i_ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]    i_ch_data,
  output logic                        o_core_start,
  output logic [$clog2(NUM_CH)-1:0]   o_core_ch,
  output logic signed [DATA_W-1:0]    o_core_x,
  input  logic                        i_core_done,
  input  logic signed [DATA_W-1:0]    i_core_y,
  output logic                        o_y_valid,
  input  logic                        i_y_ready,
  output logic [$clog2(NUM_CH)-1:0]   o_y_ch,
  output logic signed [DATA_W-1:0]    o_y_data,
  output logic [NUM_CH-1:0]           o_overrun,
  input  logic [NUM_CH-1:0]           i_ovr_clr,
  output logic                        o_busy,
  output logic                        o_wdog_err
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 32 || WDOG_CYC < 1) begin : g_bad_cfg
    $error("hp_ch_sched: unsupported NUM_CH or WDOG_CYC");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

  state_t                    state, state_nxt;
  logic [NUM_CH-1:0]         pending, pending_nxt, ovr_nxt;
  logic signed [DATA_W-1:0]  hold [NUM_CH];
  logic [CH_W-1:0]           sel, last_ch, grant;
  logic signed [DATA_W-1:0]  grant_x;
  logic                      wdog_expire;

  // First requesting channel after 'last', wrapping from NUM_CH-1 to 0.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last) + i) % NUM_CH);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign grant = rr_pick(pending, last_ch);

  // A sample arriving in the grant cycle is newer than the held one, so forward it.
  always_comb begin
    grant_x = hold[grant];
    if (i_ch_valid[grant]) grant_x = i_ch_data[int'(grant)*DATA_W +: DATA_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (i_core_done)      state_nxt = OUT;
               else if (wdog_expire) state_nxt = IDLE;
      OUT:     if (i_y_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_core_start = (state == ISSUE);
    o_y_valid    = (state == OUT);
    o_busy       = (state != IDLE);
  end

  // Pending/overrun update: issuing a channel consumes its pending bit, and a
  // capture in that same cycle re-arms it without counting as an overrun.
  always_comb begin
    logic issue_clr;
    issue_clr   = 1'b0;
    pending_nxt = pending;
    ovr_nxt     = o_overrun;
    for (int k = 0; k < NUM_CH; k++) begin
      issue_clr      = (state == ISSUE) && (sel == CH_W'(k));
      pending_nxt[k] = i_ch_valid[k] | (pending[k] & ~issue_clr);
      ovr_nxt[k]     = (i_ch_valid[k] & pending[k] & ~issue_clr) |
                       (o_overrun[k] & ~i_ovr_clr[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (i_ch_valid[k]) hold[k] <= i_ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending   <= '0;
      o_overrun <= '0;
      sel       <= '0;
      last_ch   <= CH_W'(NUM_CH - 1);
      o_core_ch <= '0;
      o_core_x  <= '0;
      o_y_ch    <= '0;
      o_y_data  <= '0;
    end else begin
      pending   <= pending_nxt;
      o_overrun <= ovr_nxt;
      if (state == IDLE && |pending) begin
        sel       <= grant;
        o_core_ch <= grant;
        o_core_x  <= grant_x;
      end
      if (state == WAIT && i_core_done) begin
        o_y_data <= i_core_y;
        o_y_ch   <= sel;
      end
      if ((state == OUT && i_y_ready) || wdog_expire) last_ch <= sel;
    end
  end

`ifdef HP_SCHED_WDOG_EN
  localparam int WC_W = $clog2(WDOG_CYC + 1);
  logic [WC_W-1:0] wdog_cnt;

  assign wdog_expire = (state == WAIT) && !i_core_done && (wdog_cnt == WC_W'(WDOG_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_cnt   <= '0;
      o_wdog_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + WC_W'(1);
      if (wdog_expire) o_wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign o_wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hp_ch_sched.sv
// Directed self-checking bench for hp_ch_sched (NUM_CH=4, DATA_W=24, WDOG_CYC=64).
// The watchdog scenario runs only when HP_SCHED_WDOG_EN is defined for the build.
module tb_hp_ch_sched;
  localparam int NC = 4;
  localparam int DW = 24;
  localparam int WD = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   ch_valid;
  logic [NC*DW-1:0] ch_data;
  logic            core_start;
  logic [1:0]      core_ch;
  logic [DW-1:0]   core_x;
  logic            core_done;
  logic [DW-1:0]   core_y;
  logic            y_valid;
  logic            y_ready;
  logic [1:0]      y_ch;
  logic [DW-1:0]   y_data;
  logic [NC-1:0]   overrun;
  logic [NC-1:0]   ovr_clr;
  logic            busy;
  logic            wdog_err;

  int vectors = 0;
  int miscompares = 0;

  hp_ch_sched #(.NUM_CH(NC), .DATA_W(DW), .WDOG_CYC(WD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_valid(ch_valid), .i_ch_data(ch_data),
    .o_core_start(core_start), .o_core_ch(core_ch), .o_core_x(core_x),
    .i_core_done(core_done), .i_core_y(core_y), .o_y_valid(y_valid),
    .i_y_ready(y_ready), .o_y_ch(y_ch), .o_y_data(y_data), .o_overrun(overrun),
    .i_ovr_clr(ovr_clr), .o_busy(busy), .o_wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int ch, input logic [DW-1:0] v);
    ch_data[ch*DW +: DW] = v;
  endtask

  // Expects the start pulse exactly one cycle after the call (grant from IDLE).
  task automatic wait_start(input string tag, input int ch, input logic [DW-1:0] x);
    int n = 0;
    while (core_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_start"}, 32'(core_start), 32'd1);
    chk({tag, "_lat"}, n, 32'd1);
    chk({tag, "_ch"}, 32'(core_ch), ch);
    chk({tag, "_x"}, 32'(core_x), 32'(x));
  endtask

  // Returns done after wcyc cycles and leaves the bench in the OUT cycle.
  task automatic finish_core(input string tag, input int wcyc, input logic [DW-1:0] y,
                             input int ch, input logic [DW-1:0] x);
    for (int i = 0; i < wcyc; i++) begin
      step();
      if (i == 0) chk({tag, "_pulse1"}, 32'(core_start), 32'd0);
    end
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hold_ch"}, 32'(core_ch), ch);
    chk({tag, "_hold_x"}, 32'(core_x), 32'(x));
    chk({tag, "_nov"}, 32'(y_valid), 32'd0);
    core_done = 1'b1;
    core_y    = y;
    step();
    core_done = 1'b0;
    chk({tag, "_yv"}, 32'(y_valid), 32'd1);
    chk({tag, "_ych"}, 32'(y_ch), ch);
    chk({tag, "_ydata"}, 32'(y_data), 32'(y));
  endtask

  initial begin
    rst_n = 1'b0; ch_valid = '0; ch_data = '0; core_done = 1'b0; core_y = '0;
    y_ready = 1'b1; ovr_clr = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_yv", 32'(y_valid), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_wdog", 32'(wdog_err), 0);
    chk("rst_x", 32'(core_x), 0);
    chk("rst_ydata", 32'(y_data), 0);
    chk("rst_pend", 32'(dut.pending), 0);
    rst_n = 1'b1;
    step();

    // All four channels in one cycle: served 0,1,2,3 at one sample per 8 cycles.
    for (int k = 0; k < NC; k++) put(k, 24'h000100 + 24'(k));
    ch_valid = 4'b1111;
    step();
    ch_valid = '0;
    wait_start("rr0", 0, 24'h000100);
    finish_core("rr0", 5, 24'h00A000, 0, 24'h000100);
    step();
    wait_start("rr1", 1, 24'h000101);
    finish_core("rr1", 5, 24'h00A001, 1, 24'h000101);
    step();
    wait_start("rr2", 2, 24'h000102);
    finish_core("rr2", 5, 24'hFFFF80, 2, 24'h000102);
    step();
    wait_start("rr3", 3, 24'h000103);
    finish_core("rr3", 5, 24'h00A003, 3, 24'h000103);
    step();
    chk("rr_noovr", 32'(overrun), 0);

    // Channel 2 served while 1 and 3 arrive: wrap grants 3 before 1.
    put(2, 24'h000200);
    ch_valid = 4'b0100;
    step();
    ch_valid = '0;
    wait_start("wr2", 2, 24'h000200);
    put(1, 24'h000211); put(3, 24'h000233);
    ch_valid = 4'b1010;
    step();
    ch_valid = '0;
    finish_core("wr2", 4, 24'h000B02, 2, 24'h000200);
    step();
    wait_start("wr3", 3, 24'h000233);
    finish_core("wr3", 5, 24'h000B03, 3, 24'h000233);
    step();
    wait_start("wr1", 1, 24'h000211);
    finish_core("wr1", 5, 24'h000B01, 1, 24'h000211);
    step();

    // Channel 0 written twice before its grant: newest sample wins, overrun sticks.
    put(2, 24'h000055);
    ch_valid = 4'b0100;
    step();
    ch_valid = '0;
    wait_start("ov2", 2, 24'h000055);
    put(0, 24'h000010);
    ch_valid = 4'b0001;
    step();
    put(0, 24'h000020);
    step();
    ch_valid = '0;
    chk("ov_set", 32'(overrun), 32'h1);
    finish_core("ov2", 3, 24'h000C02, 2, 24'h000055);
    step();
    wait_start("ov0", 0, 24'h000020);
    finish_core("ov0", 5, 24'h000C00, 0, 24'h000020);
    step();
    chk("ov_sticky", 32'(overrun), 32'h1);
    ovr_clr = 4'b0001;
    step();
    ovr_clr = '0;
    chk("ov_clr", 32'(overrun), 32'h0);

    // Recapture of the channel being issued re-arms it without an overrun.
    put(1, 24'h000025);
    ch_valid = 4'b0010;
    step();
    ch_valid = '0;
    wait_start("ri1a", 1, 24'h000025);
    put(1, 24'h000030);
    ch_valid = 4'b0010;
    step();
    ch_valid = '0;
    chk("ri_noovr", 32'(overrun), 32'h0);
    finish_core("ri1a", 4, 24'h000D01, 1, 24'h000025);
    step();
    wait_start("ri1b", 1, 24'h000030);
    finish_core("ri1b", 5, 24'h000D11, 1, 24'h000030);
    step();

    // Backpressure in OUT: result held, no new issue although channel 0 waits.
    y_ready = 1'b0;
    put(3, 24'h000333);
    ch_valid = 4'b1000;
    step();
    ch_valid = '0;
    wait_start("bp3", 3, 24'h000333);
    put(0, 24'h000044);
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    finish_core("bp3", 4, 24'h7FFFFF, 3, 24'h000333);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_yv", 32'(y_valid), 32'd1);
      chk("bp_ydata", 32'(y_data), 32'h7FFFFF);
      chk("bp_ych", 32'(y_ch), 32'd3);
      chk("bp_nostart", 32'(core_start), 32'd0);
    end
    y_ready = 1'b1;
    step();
    wait_start("bp0", 0, 24'h000044);
    finish_core("bp0", 5, 24'h800000, 0, 24'h000044);
    step();

`ifdef HP_SCHED_WDOG_EN
    // Core never completes for channel 1: timeout at start+65, then channel 2 issues.
    put(1, 24'h000111); put(2, 24'h000222);
    ch_valid = 4'b0110;
    step();
    ch_valid = '0;
    wait_start("wd1", 1, 24'h000111);
    repeat (63) step();
    step();
    chk("wd_pre_err", 32'(wdog_err), 32'd0);
    chk("wd_pre_busy", 32'(busy), 32'd1);
    chk("wd_pre_yv", 32'(y_valid), 32'd0);
    step();
    chk("wd_err", 32'(wdog_err), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    step();
    chk("wd_next_start", 32'(core_start), 32'd1);
    chk("wd_next_ch", 32'(core_ch), 32'd2);
    chk("wd_next_x", 32'(core_x), 32'h000222);
    finish_core("wd2", 5, 24'h000E02, 2, 24'h000222);
    step();
    chk("wd_sticky", 32'(wdog_err), 32'd1);
`endif

    // Reset during WAIT drops the transaction and all pending requests.
    put(3, 24'h0003AB);
    ch_valid = 4'b1000;
    step();
    ch_valid = '0;
    wait_start("ra3", 3, 24'h0003AB);
    step();
    put(1, 24'h0001CD);
    ch_valid = 4'b0010;
    step();
    ch_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_pend", 32'(dut.pending), 32'd0);
    chk("ra_x", 32'(core_x), 32'd0);
    chk("ra_yv", 32'(y_valid), 32'd0);
    step();
    rst_n = 1'b1;
    core_done = 1'b1;
    core_y    = 24'h000123;
    step();
    core_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ra_no_yv", 32'(y_valid), 32'd0);
      chk("ra_no_start", 32'(core_start), 32'd0);
      step();
    end
    chk("ra_wdog", 32'(wdog_err), 32'd0);
    chk("ra_ydata", 32'(y_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hp_ch_sched.md
HP_CH_SCHED -- requirements
Module: hp_ch_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, giving the number of audio channels sharing one highpass core (legal values 2..32).
REQ-002 The block SHALL have parameter DATA_W, default 24, giving the signed sample width.
REQ-003 The block SHALL have parameter WDOG_CYC, default 64, giving the core-completion timeout in cycles.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_ch_valid, input, NUM_CH bits: per-channel new-sample strobes.
REQ-007 The block SHALL have port i_ch_data, input, NUM_CH*DATA_W bits: packed samples, with channel k in bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port o_core_start, output, 1 bit: a one-cycle start pulse to the highpass core.
REQ-009 The block SHALL have port o_core_ch, output, $clog2(NUM_CH) bits: the channel index for the core (coefficient/state select).
REQ-010 The block SHALL have port o_core_x, output, DATA_W bits: the sample presented to the core.
REQ-011 The block SHALL have port i_core_done, input, 1 bit: a one-cycle core completion pulse.
REQ-012 The block SHALL have port i_core_y, input, DATA_W bits: the core result, valid with i_core_done.
REQ-013 The block SHALL have port o_y_valid, input-side handshake output, 1 bit: filtered result valid.
REQ-014 The block SHALL have port i_y_ready, input, 1 bit: downstream ready.
REQ-015 The block SHALL have port o_y_ch, output, $clog2(NUM_CH) bits: the channel of the result.
REQ-016 The block SHALL have port o_y_data, output, DATA_W bits: the filtered result.
REQ-017 The block SHALL have port o_overrun, output, NUM_CH bits: sticky per-channel overrun flags.
REQ-018 The block SHALL have port i_ovr_clr, input, NUM_CH bits: per-channel overrun clear.
REQ-019 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-020 The block SHALL have port o_wdog_err, output, 1 bit: sticky watchdog error.

Function
REQ-021 The block SHALL capture i_ch_data[k] into a per-channel holding register and set pending[k] on every cycle in which i_ch_valid[k] is high.
REQ-022 The block SHALL set o_overrun[k] when i_ch_valid[k] arrives while pending[k] is already set and is not being cleared in that cycle; the new sample overwrites the held one.
REQ-023 If i_ovr_clr[k] and a new overrun event coincide, the set SHALL win.
REQ-024 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUT.
REQ-025 In IDLE with any pending bit set, the block SHALL grant round-robin, starting the search at last_ch+1 and wrapping at NUM_CH-1 to 0, then go to ISSUE.
REQ-026 In ISSUE, the block SHALL assert o_core_start for exactly one cycle, clear pending[sel], and go to WAIT.
REQ-027 A capture for sel in the ISSUE cycle SHALL set pending[sel] again without flagging overrun.
REQ-028 o_core_ch and o_core_x SHALL be registered at grant and held stable from ISSUE until the FSM leaves WAIT.
REQ-029 In WAIT, on i_core_done, the block SHALL register i_core_y into o_y_data and sel into o_y_ch, then go to OUT; i_core_done in any other state SHALL be ignored.
REQ-030 In OUT, o_y_valid SHALL be high, and o_y_data and o_y_ch SHALL be held stable until i_y_ready is high; on the handshake, last_ch SHALL be set to sel and the FSM SHALL return to IDLE.
REQ-031 Latency SHALL be: i_ch_valid at cycle t with the FSM in IDLE gives o_core_start at t+2, and i_core_done at cycle d gives o_y_valid at d+1.
REQ-032 The block SHALL handle at most one channel in flight; throughput is one sample per (core latency + 3) cycles when i_y_ready is held high.

Reset
REQ-033 On i_rst_n low, the block SHALL asynchronously force state=IDLE, pending=0, last_ch=NUM_CH-1 (so channel 0 is granted first), all outputs to 0 and all holding registers to 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no result emitted.
REQ-035 Reset deassertion SHALL be used synchronously to the rising edge of i_clk.

Configuration
REQ-036 When macro HP_SCHED_WDOG_EN is defined, a counter SHALL run in WAIT; if i_core_done has not arrived after WDOG_CYC cycles, the block SHALL set o_wdog_err (cleared only by reset), drop the sample and return to IDLE with last_ch=sel.
REQ-037 When HP_SCHED_WDOG_EN is undefined, WAIT SHALL wait indefinitely, o_wdog_err SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-038 The bench SHALL cover: NUM_CH=4, i_ch_valid=4'b1111 in a single cycle, core done 5 cycles after start, i_y_ready=1 -> results emitted in channel order 0,1,2,3 with no overrun.
REQ-039 The bench SHALL cover: after channel 2 is served, channels 1 and 3 pending -> channel 3 granted before channel 1 (round-robin wrap).
REQ-040 The bench SHALL cover: ch0 valid twice before its grant, with data 0x000010 then 0x000020 -> o_core_x=0x000020 and o_overrun[0]=1; then i_ovr_clr[0] pulse -> o_overrun[0]=0.
REQ-041 The bench SHALL cover: i_y_ready held 0 for 10 cycles in OUT -> o_y_valid, o_y_data and o_y_ch stable throughout, with no new o_core_start.
REQ-042 The bench SHALL cover: with HP_SCHED_WDOG_EN defined and WDOG_CYC=64, core never returns done -> o_wdog_err=1 at start+65, FSM back in IDLE, and the next pending channel issued.
REQ-043 The bench SHALL cover: i_rst_n pulsed low during WAIT -> o_busy=0 and pending=0 immediately; a later i_core_done is ignored and no o_y_valid occurs.
